// File: rtl/vga_scene_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vga_scene_ctrl_pkg
// Shared definitions for the VGA scene controller: scene encodings and the
// default pixel width (RGB 5-6-5).
// -----------------------------------------------------------------------------
package vga_scene_ctrl_pkg;

   localparam int RGB_W_DEF = 16;

   typedef enum logic [1:0] {
      SCN_START = 2'd0,
      SCN_PLAY  = 2'd1,
      SCN_END   = 2'd2
   } scene_t;

endpackage

// File: rtl/vga_frame_edge.sv
// -----------------------------------------------------------------------------
// vga_frame_edge
// Detects the falling edge of the registered vertical sync and produces a
// one-cycle frame tick the cycle after the edge is sampled.
//
// Ports:
//   i_clk         pixel clock
//   i_rst         asynchronous active-high reset
//   i_vsync       vertical sync, low during the sync pulse
//   o_frame_tick  one-cycle pulse per frame
// -----------------------------------------------------------------------------
module vga_frame_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_vsync,
   output logic o_frame_tick
);

   logic r_vsync_d;
   logic r_frame_tick;

   // The delay register resets high so a low sync at release is not seen as
   // an edge; only a genuine high-to-low transition produces a tick.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vsync_d    <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_vsync_d    <= i_vsync;
         r_frame_tick <= r_vsync_d & ~i_vsync;
      end
   end

   assign o_frame_tick = r_frame_tick;

endmodule

// File: rtl/vga_scene_ctrl.sv
// -----------------------------------------------------------------------------
// vga_scene_ctrl
// Frame-level scheduler for the 40 MHz VGA path of the snake game. Owns the
// scene state (start / play / end), applies scene changes only at frame
// boundaries, paces the game logic with frame and step ticks, and multiplexes
// the three scene pixel sources onto a registered RGB output.
//
// Ports:
//   CLK_40M     pixel clock
//   RST         asynchronous active-high reset
//   Vsync_sig   registered vertical sync, low during the sync pulse
//   Ready_sig   active-video flag aligned with the pixel sources
//   key_start   one-cycle debounced key pulse
//   game_over   one-cycle pulse from game logic
//   start_rgb   start-screen pixel
//   game_rgb    play-field pixel
//   end_rgb     end-screen pixel
//   scene       current scene (0 START, 1 PLAY, 2 END)
//   frame_tick  one-cycle pulse per frame
//   step_tick   one-cycle pulse every STEP_FRAMES frames in PLAY
//   game_rst    one-cycle pulse on entry to PLAY
//   vga_rgb     registered pixel output
// -----------------------------------------------------------------------------
module vga_scene_ctrl
   import vga_scene_ctrl_pkg::*;
#(
   parameter int RGB_W       = RGB_W_DEF,
   parameter int STEP_FRAMES = 8,
   parameter int END_HOLD    = 120
) (
   input  logic             CLK_40M,
   input  logic             RST,
   input  logic             Vsync_sig,
   input  logic             Ready_sig,
   input  logic             key_start,
   input  logic             game_over,
   input  logic [RGB_W-1:0] start_rgb,
   input  logic [RGB_W-1:0] game_rgb,
   input  logic [RGB_W-1:0] end_rgb,
   output logic [1:0]       scene,
   output logic             frame_tick,
   output logic             step_tick,
   output logic             game_rst,
   output logic [RGB_W-1:0] vga_rgb
);

   scene_t           r_scene;
   logic             r_start_pend;
   logic             r_over_pend;
   logic [7:0]       r_step_cnt;
   logic [7:0]       r_hold;
   logic             r_game_rst;
   logic [RGB_W-1:0] r_rgb;

   logic             w_frame_tick;
   logic             w_step_wrap;
   logic             w_step_tick;
   logic [RGB_W-1:0] w_pix;

   vga_frame_edge u_frame_edge (
      .i_clk        (CLK_40M),
      .i_rst        (RST),
      .i_vsync      (Vsync_sig),
      .o_frame_tick (w_frame_tick)
   );

   assign w_step_wrap = (r_step_cnt == 8'(STEP_FRAMES - 1));

   // Step tick must coincide with frame_tick, so it is decoded from registered
   // state in the frame_tick cycle; the frame that leaves PLAY gives no step.
   assign w_step_tick = w_frame_tick && (r_scene == SCN_PLAY) &&
                        !r_over_pend && w_step_wrap;

   // Scene FSM, step scheduler and request latching.
   always_ff @(posedge CLK_40M or posedge RST) begin
      if (RST) begin
         r_scene      <= SCN_START;
         r_start_pend <= 1'b0;
         r_over_pend  <= 1'b0;
         r_step_cnt   <= 8'd0;
         r_hold       <= 8'd0;
         r_game_rst   <= 1'b0;
      end else begin
         r_game_rst <= 1'b0;
         if (w_frame_tick) begin
            case (r_scene)
               SCN_START: begin
                  if (r_start_pend) begin
                     r_scene      <= SCN_PLAY;
                     r_game_rst   <= 1'b1;
                     r_start_pend <= 1'b0;
                     r_over_pend  <= 1'b0;
                     r_step_cnt   <= 8'd0;
                  end
               end
               SCN_PLAY: begin
                  r_start_pend <= 1'b0;  // keys are meaningless while playing
                  if (r_over_pend) begin
                     r_scene     <= SCN_END;
                     r_hold      <= 8'(END_HOLD);
                     r_over_pend <= 1'b0;
                     r_step_cnt  <= 8'd0;
                  end else if (w_step_wrap) begin
                     r_step_cnt <= 8'd0;
                  end else begin
                     r_step_cnt <= r_step_cnt + 8'd1;
                  end
               end
               SCN_END: begin
                  r_over_pend <= 1'b0;
                  if (r_hold != 8'd0) begin
                     // Keys during the hold period are dropped, not deferred.
                     r_hold       <= r_hold - 8'd1;
                     r_start_pend <= 1'b0;
                  end else if (r_start_pend) begin
                     r_scene      <= SCN_START;
                     r_start_pend <= 1'b0;
                  end
               end
               default: begin
                  r_scene    <= SCN_START;
                  r_step_cnt <= 8'd0;
               end
            endcase
         end
         // Placed after the FSM so a request arriving in the evaluation
         // cycle survives the clear and is served at the next frame.
         if (key_start) r_start_pend <= 1'b1;
         if (game_over) r_over_pend  <= 1'b1;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_pix = '0;
      case (r_scene)
         SCN_START: w_pix = start_rgb;
         SCN_PLAY:  w_pix = game_rgb;
         SCN_END:   w_pix = end_rgb;
         default:   w_pix = '0;
      endcase
   end

   always_ff @(posedge CLK_40M or posedge RST) begin
      if (RST) begin
         r_rgb <= '0;
      end else begin
         r_rgb <= Ready_sig ? w_pix : '0;
      end
   end

   assign scene      = r_scene;
   assign frame_tick = w_frame_tick;
   assign step_tick  = w_step_tick;
   assign game_rst   = r_game_rst;
   assign vga_rgb    = r_rgb;

endmodule
